id_exe_register: RTL and testbench
==================================

Name: id_exe_register

Overview:
- Pipeline register between the ID stage and the EXE stage of the ARM core. It captures decoded control, operands and the shifter field each cycle.
- It drives the EXE-stage consumers: the val2 generator (memInst, imm, valRm, shifterOperand), the ALU, the branch-target adder and the status-register logic.
- It supports freeze (hold on hazard), flush (squash on taken branch) and a valid bit, so downstream stages can tell real instructions from bubbles.

Parameters:
- DATA_W, 32, width of PC and operand values.
- REG_W, 4, width of register-file addresses.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- freeze  in  1  hold all stored state this cycle.
- flush  in  1  replace the stored instruction with a bubble.
- validIn  in  1  ID holds a real instruction (0 = bubble from hazard insertion).
- pcIn  in  DATA_W  PC+4 of the ID instruction.
- wbEnIn, memREnIn, memWEnIn, bIn, sIn, immIn  in  1 each  decoded control bits.
- exeCmdIn  in  4  ALU command.
- valRnIn, valRmIn  in  DATA_W  register-file read values.
- shifterOperandIn  in  12  instruction bits [11:0].
- signedImm24In  in  24  branch offset.
- destIn, src1In, src2In  in  REG_W  destination and source register indices.
- carryIn  in  1  current status-register C flag.
- Outputs: each of the above inputs except clk, rst, freeze and flush, renamed *Out, same widths; validIn becomes validOut.
- memInstOut  out  1  registered (memREnIn | memWEnIn).

Behaviour:
- Reset (rst=0, asynchronous):
  - All outputs go to 0 immediately and stay 0 while rst is low.
  - This includes validOut, memInstOut, pcOut and every data field.
  - The first capture happens on the first rising edge after rst deasserts.
- Each rising edge, one action applies, highest priority first:
  1. flush=1: load a bubble. validOut, wbEnOut, memREnOut, memWEnOut, memInstOut, bOut and sOut all become 0. All data fields (pc, valRn, valRm, shifterOperand, signedImm24, dest, src1, src2, exeCmd, imm, carry) also become 0. Flush overrides freeze.
  2. freeze=1 (flush=0): every output holds its previous value.
  3. Otherwise: capture all inputs.
     - validOut = validIn.
     - If validIn=0, the control bits (wbEn, memREn, memWEn, memInst, b, s) are forced to 0. Data fields are still captured, which keeps bench visibility.
- Latency:
  - Exactly one cycle from input to output when not frozen or flushed.
  - No combinational path from any input to any output.
- Invariant: memInstOut == (memREnOut | memWEnOut) at all times, including after reset, flush, freeze and bubble capture.
- carryOut is the C flag sampled when the instruction enters EXE. ADC/SBC/RSC use this value, not the live flag.
- Widths: pure storage, no arithmetic. signedImm24 is stored unextended; sign extension belongs to EXE.
- Reset mid-operation:
  - Asynchronous clear wins over any simultaneous freeze or flush.
  - When rst deasserts with freeze=1, the register keeps holding zeros until freeze drops.
- freeze and flush both high for N consecutive cycles: the output is a bubble for all N cycles.

Decomposition:
- Shared package/header holds:
  - EXE_CMD_* 4-bit constants (MOV=0001, MVN=1001, ADD=0010, ADC=0011, SUB=0100, SBC=0101, AND=0110, ORR=0111, EOR=1000, CMP=0100, TST=0110, LDR/STR=0010).
  - DATA_W and REG_W defaults.
- One natural sub-module: pipe_reg, a generic WIDTH-parameterised register with async active-low reset, freeze (hold) and flush (clear-to-zero).
  - id_exe_register instantiates it once for the control bits and once for the data fields.
  - The bubble masking and the memInst OR sit in the wrapper.

Test Plan:
- Reset: drive all inputs to 1s, pulse rst=0 between clock edges. All outputs read 0 without waiting for a clock edge. After release, one edge with validIn=1 and pcIn=0x00000008 gives pcOut=0x00000008 and validOut=1.
- Normal capture: memREnIn=1, immIn=0, shifterOperandIn=0x104, valRmIn=0x0000000F, destIn=3. After one edge: memInstOut=1, shifterOperandOut=0x104, valRmOut=0x0000000F, destOut=3, and the outputs are unchanged before that edge.
- Freeze: load wbEnIn=1, exeCmdIn=0010. Then assert freeze for 3 cycles while the inputs change to wbEnIn=0, exeCmdIn=0100. Outputs stay wbEnOut=1, exeCmdOut=0010 for all 3 edges, then update one edge after freeze drops.
- Flush over freeze: after a valid STR load (memWEnOut=1), assert freeze=1 and flush=1 together. On the next edge validOut=0, memWEnOut=0, memInstOut=0, pcOut=0.
- Bubble capture: validIn=0, wbEnIn=1, sIn=1, valRnIn=0x12345678. After the edge: validOut=0, wbEnOut=0, sOut=0, valRnOut=0x12345678.
- Carry snapshot: carryIn=1 with ADC (exeCmdIn=0011) captured; next cycle carryIn=0 with freeze=1. carryOut stays 1.

Source files
------------

// File: rtl/id_exe_register_pkg.sv
// Shared definitions for the ID/EXE pipeline register: ALU command encodings,
// default widths and the layout of the stored control bits.
package id_exe_register_pkg;

    localparam int DATA_W_DEFAULT = 32;
    localparam int REG_W_DEFAULT  = 4;

    localparam logic [3:0] EXE_CMD_MOV = 4'b0001;
    localparam logic [3:0] EXE_CMD_MVN = 4'b1001;
    localparam logic [3:0] EXE_CMD_ADD = 4'b0010;
    localparam logic [3:0] EXE_CMD_ADC = 4'b0011;
    localparam logic [3:0] EXE_CMD_SUB = 4'b0100;
    localparam logic [3:0] EXE_CMD_SBC = 4'b0101;
    localparam logic [3:0] EXE_CMD_AND = 4'b0110;
    localparam logic [3:0] EXE_CMD_ORR = 4'b0111;
    localparam logic [3:0] EXE_CMD_EOR = 4'b1000;
    localparam logic [3:0] EXE_CMD_CMP = 4'b0100;
    localparam logic [3:0] EXE_CMD_TST = 4'b0110;
    localparam logic [3:0] EXE_CMD_LDR = 4'b0010;
    localparam logic [3:0] EXE_CMD_STR = 4'b0010;

    // Control bits that must read as zero whenever the slot holds a bubble.
    typedef struct packed {
        logic valid;
        logic wbEn;
        logic memREn;
        logic memWEn;
        logic memInst;
        logic b;
        logic s;
    } ctrl_t;

endpackage

// File: rtl/id_exe_register_pipe_reg.sv
// Generic pipeline register: async active-low clear, flush clears to zero,
// freeze holds; flush takes priority over freeze.
module pipe_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             freeze,
    input  logic             flush,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Storage with clear / hold / load priority.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (flush) begin
            q <= '0;
        end else if (!freeze) begin
            q <= d;
        end
    end

endmodule

// File: rtl/id_exe_register.sv
// ID/EXE pipeline register. Control bits are masked to zero for bubbles
// before capture, so a stored bubble never enables writeback, memory access,
// branching or flag updates. memInst is registered alongside the other
// control bits so it always agrees with memREn | memWEn.
module id_exe_register
    import id_exe_register_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int REG_W  = REG_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              flush,
    input  logic              validIn,
    input  logic [DATA_W-1:0] pcIn,
    input  logic              wbEnIn,
    input  logic              memREnIn,
    input  logic              memWEnIn,
    input  logic              bIn,
    input  logic              sIn,
    input  logic              immIn,
    input  logic [3:0]        exeCmdIn,
    input  logic [DATA_W-1:0] valRnIn,
    input  logic [DATA_W-1:0] valRmIn,
    input  logic [11:0]       shifterOperandIn,
    input  logic [23:0]       signedImm24In,
    input  logic [REG_W-1:0]  destIn,
    input  logic [REG_W-1:0]  src1In,
    input  logic [REG_W-1:0]  src2In,
    input  logic              carryIn,
    output logic              validOut,
    output logic [DATA_W-1:0] pcOut,
    output logic              wbEnOut,
    output logic              memREnOut,
    output logic              memWEnOut,
    output logic              memInstOut,
    output logic              bOut,
    output logic              sOut,
    output logic              immOut,
    output logic [3:0]        exeCmdOut,
    output logic [DATA_W-1:0] valRnOut,
    output logic [DATA_W-1:0] valRmOut,
    output logic [11:0]       shifterOperandOut,
    output logic [23:0]       signedImm24Out,
    output logic [REG_W-1:0]  destOut,
    output logic [REG_W-1:0]  src1Out,
    output logic [REG_W-1:0]  src2Out,
    output logic              carryOut
);

    localparam int CTRL_W = $bits(ctrl_t);
    localparam int DATA_BITS = 3 * DATA_W + 4 + 1 + 12 + 24 + 3 * REG_W + 1;

    ctrl_t                ctrlD;
    ctrl_t                ctrlQ;
    logic [DATA_BITS-1:0] dataD;
    logic [DATA_BITS-1:0] dataQ;

    // Bubble masking: an invalid slot carries no side-effecting control.
    always_comb begin
        ctrlD         = '0;
        ctrlD.valid   = validIn;
        ctrlD.wbEn    = validIn & wbEnIn;
        ctrlD.memREn  = validIn & memREnIn;
        ctrlD.memWEn  = validIn & memWEnIn;
        ctrlD.memInst = validIn & (memREnIn | memWEnIn);
        ctrlD.b       = validIn & bIn;
        ctrlD.s       = validIn & sIn;
    end

    // Data fields are captured even for bubbles; signedImm24 stays unextended.
    assign dataD = {pcIn, exeCmdIn, immIn, valRnIn, valRmIn, shifterOperandIn,
                    signedImm24In, destIn, src1In, src2In, carryIn};

    pipe_reg #(.WIDTH(CTRL_W)) ctrlReg (
        .clk    (clk),
        .rst    (rst),
        .freeze (freeze),
        .flush  (flush),
        .d      (ctrlD),
        .q      (ctrlQ)
    );

    pipe_reg #(.WIDTH(DATA_BITS)) dataReg (
        .clk    (clk),
        .rst    (rst),
        .freeze (freeze),
        .flush  (flush),
        .d      (dataD),
        .q      (dataQ)
    );

    assign validOut   = ctrlQ.valid;
    assign wbEnOut    = ctrlQ.wbEn;
    assign memREnOut  = ctrlQ.memREn;
    assign memWEnOut  = ctrlQ.memWEn;
    assign memInstOut = ctrlQ.memInst;
    assign bOut       = ctrlQ.b;
    assign sOut       = ctrlQ.s;

    assign {pcOut, exeCmdOut, immOut, valRnOut, valRmOut, shifterOperandOut,
            signedImm24Out, destOut, src1Out, src2Out, carryOut} = dataQ;

endmodule

// File: tb/tb_id_exe_register.sv
module tb_id_exe_register;

    typedef struct packed {
        logic        valid, wbEn, memREn, memWEn, b, s, imm, carry;
        logic [3:0]  exeCmd;
        logic [31:0] pc, valRn, valRm;
        logic [11:0] shOp;
        logic [23:0] imm24;
        logic [3:0]  dest, src1, src2;
    } inRec_t;

    typedef struct packed {
        logic        valid, wbEn, memREn, memWEn, memInst, b, s, imm, carry;
        logic [3:0]  exeCmd;
        logic [31:0] pc, valRn, valRm;
        logic [11:0] shOp;
        logic [23:0] imm24;
        logic [3:0]  dest, src1, src2;
    } outRec_t;

    typedef struct {
        inRec_t in;
        logic   freeze;
        logic   flush;
    } vec_t;

    logic        clk, rst, freeze, flush;
    logic        validIn, wbEnIn, memREnIn, memWEnIn, bIn, sIn, immIn, carryIn;
    logic [3:0]  exeCmdIn;
    logic [31:0] pcIn, valRnIn, valRmIn;
    logic [11:0] shifterOperandIn;
    logic [23:0] signedImm24In;
    logic [3:0]  destIn, src1In, src2In;

    logic        validOut, wbEnOut, memREnOut, memWEnOut, memInstOut, bOut, sOut, immOut, carryOut;
    logic [3:0]  exeCmdOut;
    logic [31:0] pcOut, valRnOut, valRmOut;
    logic [11:0] shifterOperandOut;
    logic [23:0] signedImm24Out;
    logic [3:0]  destOut, src1Out, src2Out;

    outRec_t actOut;
    assign actOut = {validOut, wbEnOut, memREnOut, memWEnOut, memInstOut, bOut, sOut, immOut,
                     carryOut, exeCmdOut, pcOut, valRnOut, valRmOut, shifterOperandOut,
                     signedImm24Out, destOut, src1Out, src2Out};

    id_exe_register dut (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
        .validIn(validIn), .pcIn(pcIn), .wbEnIn(wbEnIn), .memREnIn(memREnIn),
        .memWEnIn(memWEnIn), .bIn(bIn), .sIn(sIn), .immIn(immIn), .exeCmdIn(exeCmdIn),
        .valRnIn(valRnIn), .valRmIn(valRmIn), .shifterOperandIn(shifterOperandIn),
        .signedImm24In(signedImm24In), .destIn(destIn), .src1In(src1In), .src2In(src2In),
        .carryIn(carryIn),
        .validOut(validOut), .pcOut(pcOut), .wbEnOut(wbEnOut), .memREnOut(memREnOut),
        .memWEnOut(memWEnOut), .memInstOut(memInstOut), .bOut(bOut), .sOut(sOut),
        .immOut(immOut), .exeCmdOut(exeCmdOut), .valRnOut(valRnOut), .valRmOut(valRmOut),
        .shifterOperandOut(shifterOperandOut), .signedImm24Out(signedImm24Out),
        .destOut(destOut), .src1Out(src1Out), .src2Out(src2Out), .carryOut(carryOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nChecks = 0;
    int nFail   = 0;
    outRec_t sbQ[$];

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyIn(input inRec_t i);
        validIn = i.valid;   wbEnIn = i.wbEn;     memREnIn = i.memREn; memWEnIn = i.memWEn;
        bIn = i.b;           sIn = i.s;           immIn = i.imm;       carryIn = i.carry;
        exeCmdIn = i.exeCmd; pcIn = i.pc;         valRnIn = i.valRn;   valRmIn = i.valRm;
        shifterOperandIn = i.shOp; signedImm24In = i.imm24;
        destIn = i.dest;     src1In = i.src1;     src2In = i.src2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic outRec_t model(input outRec_t cur, input inRec_t i, input logic fr, input logic fl);
        outRec_t n;
        if (fl) begin
            n = '0;
        end else if (fr) begin
            n = cur;
        end else begin
            n.valid   = i.valid;
            n.wbEn    = i.valid & i.wbEn;
            n.memREn  = i.valid & i.memREn;
            n.memWEn  = i.valid & i.memWEn;
            n.memInst = i.valid & (i.memREn | i.memWEn);
            n.b       = i.valid & i.b;
            n.s       = i.valid & i.s;
            n.imm     = i.imm;     n.carry = i.carry;  n.exeCmd = i.exeCmd;
            n.pc      = i.pc;      n.valRn = i.valRn;  n.valRm  = i.valRm;
            n.shOp    = i.shOp;    n.imm24 = i.imm24;
            n.dest    = i.dest;    n.src1  = i.src1;   n.src2   = i.src2;
        end
        return n;
    endfunction

    initial begin
        inRec_t  in;
        outRec_t exp, cur;
        vec_t    vecs[24];

        for (int k = 0; k < 24; k++) begin
            vecs[k].in     = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            vecs[k].freeze = ($urandom_range(0, 3) == 0);
            vecs[k].flush  = ($urandom_range(0, 6) == 0);
        end
        vecs[0].flush = 1'b1;
        for (int k = 10; k < 13; k++) begin
            vecs[k].freeze = 1'b1;
            vecs[k].flush  = 1'b1;
        end
        vecs[13].freeze = 1'b0;
        vecs[13].flush  = 1'b0;
        vecs[14].freeze = 1'b1;
        vecs[14].flush  = 1'b0;

        // Reset behaviour
        rst = 1'b1; freeze = 1'b0; flush = 1'b0;
        applyIn('0);
        #2 rst = 1'b0;
        #1 check("reset_initial", actOut, '0);
        tick();
        tick();
        check("reset_held", actOut, '0);
        in = '1;
        applyIn(in);
        rst = 1'b1;
        tick();
        check("load_all_ones", actOut, outRec_t'('1));
        #2 rst = 1'b0;
        #1 check("reset_async", actOut, '0);
        #1 rst = 1'b1;
        in = '0; in.valid = 1'b1; in.pc = 32'h8;
        applyIn(in);
        tick();
        check("first_pc", pcOut, 32'h8);
        check("first_valid", validOut, 1);

        // Normal capture
        in = '0; in.valid = 1'b1; in.memREn = 1'b1; in.shOp = 12'h104; in.valRm = 32'hF; in.dest = 4'd3;
        applyIn(in);
        #1;
        exp = '0; exp.valid = 1'b1; exp.pc = 32'h8;
        check("norm_before_edge", actOut, exp);
        tick();
        check("norm_memInst", memInstOut, 1);
        check("norm_memREn", memREnOut, 1);
        check("norm_shOp", shifterOperandOut, 12'h104);
        check("norm_valRm", valRmOut, 32'hF);
        check("norm_dest", destOut, 3);
        check("norm_pc", pcOut, 0);

        // Freeze for three cycles
        in = '0; in.valid = 1'b1; in.wbEn = 1'b1; in.exeCmd = 4'b0010;
        applyIn(in);
        tick();
        check("frz_load_wbEn", wbEnOut, 1);
        check("frz_load_cmd", exeCmdOut, 4'b0010);
        freeze = 1'b1;
        in.wbEn = 1'b0; in.exeCmd = 4'b0100;
        applyIn(in);
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("frz_hold_wbEn_%0d", k), wbEnOut, 1);
            check($sformatf("frz_hold_cmd_%0d", k), exeCmdOut, 4'b0010);
        end
        freeze = 1'b0;
        tick();
        check("frz_release_wbEn", wbEnOut, 0);
        check("frz_release_cmd", exeCmdOut, 4'b0100);

        // Flush overrides freeze
        in = '0; in.valid = 1'b1; in.memWEn = 1'b1; in.pc = 32'h100; in.exeCmd = 4'b0010;
        applyIn(in);
        tick();
        check("str_memWEn", memWEnOut, 1);
        check("str_memInst", memInstOut, 1);
        freeze = 1'b1; flush = 1'b1;
        tick();
        check("flush_valid", validOut, 0);
        check("flush_memWEn", memWEnOut, 0);
        check("flush_memInst", memInstOut, 0);
        check("flush_pc", pcOut, 0);
        tick();
        tick();
        check("flush_multi", actOut, '0);
        freeze = 1'b0; flush = 1'b0;

        // Bubble capture
        in = '0; in.valid = 1'b0; in.wbEn = 1'b1; in.s = 1'b1; in.valRn = 32'h12345678;
        applyIn(in);
        tick();
        check("bub_valid", validOut, 0);
        check("bub_wbEn", wbEnOut, 0);
        check("bub_s", sOut, 0);
        check("bub_valRn", valRnOut, 32'h12345678);

        // Carry snapshot under freeze
        in = '0; in.valid = 1'b1; in.exeCmd = 4'b0011; in.carry = 1'b1;
        applyIn(in);
        tick();
        check("carry_load", carryOut, 1);
        in.carry = 1'b0;
        applyIn(in);
        freeze = 1'b1;
        tick();
        check("carry_hold", carryOut, 1);
        check("carry_cmd", exeCmdOut, 4'b0011);

        // Reset mid-operation while frozen: zeros held until freeze drops
        #2 rst = 1'b0;
        #1 check("rst_frz_async", actOut, '0);
        rst = 1'b1;
        tick();
        check("rst_frz_hold0", actOut, '0);
        in = '0; in.valid = 1'b1; in.pc = 32'h44;
        applyIn(in);
        tick();
        check("rst_frz_hold1", actOut, '0);
        freeze = 1'b0;
        tick();
        check("rst_frz_pc", pcOut, 32'h44);
        check("rst_frz_valid", validOut, 1);

        // Table-driven scoreboard run
        cur = '0;
        for (int k = 0; k < 24; k++) begin
            applyIn(vecs[k].in);
            freeze = vecs[k].freeze;
            flush  = vecs[k].flush;
            cur = model(cur, vecs[k].in, vecs[k].freeze, vecs[k].flush);
            sbQ.push_back(cur);
            tick();
            if (sbQ.size() == 0) begin
                nChecks++;
                nFail++;
                $display("FAIL sb_empty_%0d: queue size 0 required 1", k);
            end else begin
                exp = sbQ.pop_front();
                check($sformatf("vec_%0d", k), actOut, exp);
                check($sformatf("vec_inv_%0d", k), memInstOut, memREnOut | memWEnOut);
            end
        end
        freeze = 1'b0; flush = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
